ibex_counter_bank_ctrl: RTL

IBEX_COUNTER_BANK_CTRL -- requirements
Module: ibex_counter_bank_ctrl

---
 rtl/ibex_counter_bank_ctrl.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ibex_counter_bank_ctrl.sv
// Bank of event counters with split 32-bit CSR writes, an inhibit mask and registered reads.
// Optional sticky overflow flags and interrupt are enabled by defining IBEX_COUNTER_BANK_OVF_IRQ_EN.
module ibex_counter_bank_ctrl #(
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned CounterWidth = 40
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [NumCounters-1:0] event_i,
    input  logic [2:0]             wr_idx_i,
    input  logic                   wr_lo_i,
    input  logic                   wr_hi_i,
    input  logic [31:0]            csr_wdata_i,
    input  logic                   inhibit_we_i,
    input  logic [NumCounters-1:0] inhibit_wdata_i,
    output logic [NumCounters-1:0] inhibit_o,
    input  logic                   rd_req_i,
    input  logic [2:0]             rd_idx_i,
    output logic                   rd_valid_o,
    output logic [63:0]            rd_data_o,
    output logic [NumCounters-1:0] ovf_o,
    output logic                   irq_o
);

    logic [CounterWidth-1:0] cnt_q [NumCounters];
    logic [CounterWidth-1:0] cnt_d [NumCounters];
    logic [NumCounters-1:0]  inhibit_q;
    logic [NumCounters-1:0]  wr_en;
    logic [NumCounters-1:0]  inc;
    logic [63:0]             cur_ext;
    logic [63:0]             wr_val;
    logic [63:0]             rd_sel;
    logic                    rd_valid_q;
    logic [63:0]             rd_data_q;

    // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
    always_comb begin
        wr_en   = '0;
        inc     = '0;
        cur_ext = '0;
        wr_val  = '0;
        for (int k = 0; k < NumCounters; k++) begin
            cnt_d[k] = cnt_q[k];
            wr_en[k] = (wr_lo_i || wr_hi_i) && (wr_idx_i == 3'(k));
            inc[k]   = event_i[k] && !inhibit_q[k] && !wr_en[k];
            if (wr_en[k]) begin
                cur_ext                   = '0;
                cur_ext[CounterWidth-1:0] = cnt_q[k];
                // The high-half write wins when both halves are strobed together.
                wr_val   = wr_hi_i ? {csr_wdata_i, cur_ext[31:0]} : {cur_ext[63:32], csr_wdata_i};
                cnt_d[k] = wr_val[CounterWidth-1:0];
            end else if (inc[k]) begin
                cnt_d[k] = cnt_q[k] + CounterWidth'(1);
            end
        end
    end

    // Indices at or above NumCounters match no counter and read back as zero.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NumCounters; k++) begin
            if (rd_idx_i == 3'(k)) begin
                rd_sel[CounterWidth-1:0] = cnt_q[k];
            end
        end
    end

    // NOTE: the counter array is reset explicitly because software relies on zero counts after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < NumCounters; k++) begin
                cnt_q[k] <= '0;
            end
            inhibit_q  <= '1;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            for (int k = 0; k < NumCounters; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            if (inhibit_we_i) begin
                inhibit_q <= inhibit_wdata_i;
            end
            rd_valid_q <= rd_req_i;
            if (rd_req_i) begin
                rd_data_q <= rd_sel;
            end
        end
    end

    assign inhibit_o  = inhibit_q;
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;

`ifdef IBEX_COUNTER_BANK_OVF_IRQ_EN
    logic [NumCounters-1:0] wrap;
    logic [NumCounters-1:0] ovf_q;
    logic                   irq_q;

    always_comb begin
        wrap = '0;
        for (int k = 0; k < NumCounters; k++) begin
            wrap[k] = inc[k] && (cnt_q[k] == {CounterWidth{1'b1}});
        end
    end

    // A write to a counter clears its flag and overrides a same-cycle wrap.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q | wrap) & ~wr_en;
            irq_q <= |ovf_q;
        end
    end

    assign ovf_o = ovf_q;
    assign irq_o = irq_q;
`else
    assign ovf_o = '0;
    assign irq_o = 1'b0;
`endif

endmodule
